rally_referee: RTL and testbench



---
 rtl/rally_referee_pkg.sv | 25 ++
 rtl/rally_referee_if.sv | 16 +
 rtl/rally_referee_edge_rise.sv | 20 ++
 rtl/rally_referee.sv | 108 ++++++++++
 tb/tb_rally_referee.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rally_referee_pkg.sv
// Shared game definitions for the ball and referee blocks: Game_state
// encodings and playfield geometry.
package pika_pkg;

  localparam int COORD_W = 12;

  // Game_state encodings (legacy-compatible constants, shared with the ball block)
  localparam logic [1:0] GS_START     = 2'd0;
  localparam logic [1:0] GS_WAIT_DROP = 2'd1;
  localparam logic [1:0] GS_IN_GAME   = 2'd2;
  localparam logic [1:0] GS_GAME_END  = 2'd3;

  // Playfield geometry in pixels
  localparam int BALL_W    = 30;
  localparam int BALL_H    = 30;
  localparam int NET_POS_X = 160;
  localparam int NET_W     = 6;
  localparam int GROUND_Y  = 220;
  localparam int VBUF_W    = 320;
  localparam int VBUF_H    = 240;

  // Ball centre x strictly below this value lies in the NPC court
  localparam int NET_CENTER_X = NET_POS_X + NET_W / 2;

endpackage

// File: rtl/rally_referee_if.sv
// Ball <-> referee link: ball position one way, game state and last winner
// the other way.
interface rally_referee_if;
  import pika_pkg::*;

  logic [COORD_W-1:0] Ball_X;
  logic [COORD_W-1:0] Ball_Y;
  logic [1:0]         Game_state;
  logic               who_win;

  // Ball physics side
  modport master (output Ball_X, Ball_Y, input Game_state, who_win);
  // Referee side
  modport slave  (input Ball_X, Ball_Y, output Game_state, who_win);

endinterface

// File: rtl/rally_referee_edge_rise.sv
// 1-bit registered rising-edge detector for the start button.
module edge_rise (
  input  logic clk,
  input  logic d,
  output logic rise
);

  logic prev;

  // Track the previous level every cycle, reset included: a button held
  // through reset then reads as already pressed and needs release + press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/rally_referee.sv
// Game-flow controller: detects ball landing, awards points, keeps scores,
// times the serve drop and ends the match at WIN_SCORE.
module rally_referee
  import pika_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int DROP_CYCLES = 100_000_000,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_btn,
  rally_referee_if.slave     ball,
  output logic               point_pulse,
  output logic [SCORE_W-1:0] Player_score,
  output logic [SCORE_W-1:0] NPC_score
);

  localparam int CNT_W = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   DROP_LAST = CNT_W'(DROP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic [1:0]         state;
  logic               who_win_q;
  logic [CNT_W-1:0]   drop_cnt;
  logic               btn_rise;
  logic [COORD_W:0]   center_x;
  logic [COORD_W:0]   ball_bottom;
  logic               npc_court;
  logic               grounded;
  logic [SCORE_W-1:0] player_next;
  logic [SCORE_W-1:0] npc_next;

  edge_rise u_btn_edge (
    .clk  (clk),
    .d    (start_btn),
    .rise (btn_rise)
  );

  // One extra bit keeps the geometry sums from wrapping near the screen edge
  assign center_x    = {1'b0, ball.Ball_X} + (COORD_W+1)'(BALL_W / 2);
  assign ball_bottom = {1'b0, ball.Ball_Y} + (COORD_W+1)'(BALL_H);
  assign npc_court   = center_x < (COORD_W+1)'(NET_CENTER_X);
  assign grounded    = ball_bottom >= (COORD_W+1)'(GROUND_Y);

  assign player_next = Player_score + 1'b1;
  assign npc_next    = NPC_score + 1'b1;

  // Match FSM, serve-drop timer, scores and the point strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= GS_START;
      who_win_q    <= 1'b0;
      point_pulse  <= 1'b0;
      Player_score <= '0;
      NPC_score    <= '0;
      drop_cnt     <= '0;
    end else begin
      point_pulse <= 1'b0;
      case (state)
        GS_START: begin
          Player_score <= '0;
          NPC_score    <= '0;
          if (btn_rise) begin
            state    <= GS_WAIT_DROP;
            drop_cnt <= '0;
          end
        end
        GS_WAIT_DROP: begin
          if (drop_cnt == DROP_LAST) begin
            state    <= GS_IN_GAME;
            drop_cnt <= '0;
          end else begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
        GS_IN_GAME: begin
          // Leaving IN_GAME on the scoring edge is what limits a rally to one point
          if (grounded) begin
            point_pulse <= 1'b1;
            drop_cnt    <= '0;
            if (npc_court) begin
              Player_score <= player_next;
              who_win_q    <= 1'b0;
              state        <= (player_next == WIN_VAL) ? GS_GAME_END : GS_WAIT_DROP;
            end else begin
              NPC_score <= npc_next;
              who_win_q <= 1'b1;
              state     <= (npc_next == WIN_VAL) ? GS_GAME_END : GS_WAIT_DROP;
            end
          end
        end
        default: begin
          // GAME_END: hold scores for display; who_win kept so the winner serves
          if (btn_rise) begin
            state        <= GS_START;
            Player_score <= '0;
            NPC_score    <= '0;
          end
        end
      endcase
    end
  end

  assign ball.Game_state = state;
  assign ball.who_win    = who_win_q;

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee with a 10-cycle serve drop.
module tb_rally_referee;

  localparam int DROP = 10;
  localparam int WIN  = 7;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_btn;
  logic          point_pulse;
  logic [SW-1:0] Player_score;
  logic [SW-1:0] NPC_score;

  int n_tests = 0;
  int n_fail  = 0;

  rally_referee_if bif ();

  rally_referee #(
    .WIN_SCORE   (WIN),
    .DROP_CYCLES (DROP),
    .SCORE_W     (SW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .ball         (bif),
    .point_pulse  (point_pulse),
    .Player_score (Player_score),
    .NPC_score    (NPC_score)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input int gs, input int ww, input int pp,
                         input int ps, input int ns);
    chk({name, ".Game_state"}, int'(bif.Game_state), gs);
    chk({name, ".who_win"}, int'(bif.who_win), ww);
    chk({name, ".point_pulse"}, int'(point_pulse), pp);
    chk({name, ".Player_score"}, int'(Player_score), ps);
    chk({name, ".NPC_score"}, int'(NPC_score), ns);
  endtask

  task automatic press();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  // Bounded wait for IN_GAME; expiry counts as a failure
  task automatic wait_in_game();
    int k = 0;
    while (bif.Game_state !== 2'd2 && k < 4 * DROP) begin
      step();
      k++;
    end
    chk("wait_in_game", int'(bif.Game_state), 2);
  endtask

  // Land the ball at (x, y) for one cycle, then lift it back into the air
  task automatic land(input int x, input int y);
    bif.Ball_X = 12'(x);
    bif.Ball_Y = 12'(y);
    step();
    bif.Ball_Y = 12'd0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    start_btn = 1'b0;
    bif.Ball_X = 12'd0;
    bif.Ball_Y = 12'd0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    chk("reset.idle", int'(bif.Game_state), 0);
  endtask

  task automatic test_serve_delay();
    press();
    chk("serve.enter_wait", int'(bif.Game_state), 1);
    for (int i = 1; i < DROP; i++) step();
    chk("serve.still_wait", int'(bif.Game_state), 1);
    step();
    chk("serve.in_game", int'(bif.Game_state), 2);
  endtask

  task automatic test_player_point();
    land(100, 190);
    chk_all("player_pt", 1, 0, 1, 1, 0);
    step();
    chk("player_pt.pulse_off", int'(point_pulse), 0);
    chk("player_pt.wait", int'(bif.Game_state), 1);
  endtask

  task automatic test_npc_hold();
    wait_in_game();
    bif.Ball_X = 12'd200;
    bif.Ball_Y = 12'd195;
    step();
    chk_all("npc_pt", 1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) step();
    chk_all("npc_hold", 1, 1, 0, 1, 1);
    bif.Ball_Y = 12'd0;
  endtask

  task automatic test_boundary();
    wait_in_game();
    // Bottom at 219: just above the floor, no point
    bif.Ball_X = 12'd100;
    bif.Ball_Y = 12'd189;
    step();
    step();
    chk("bnd.not_grounded_state", int'(bif.Game_state), 2);
    chk("bnd.not_grounded_pulse", int'(point_pulse), 0);
    land(133, 190);
    chk("bnd.x133_player", int'(Player_score), 2);
    chk("bnd.x133_who", int'(bif.who_win), 0);
    wait_in_game();
    land(148, 190);
    chk("bnd.x148_npc", int'(NPC_score), 2);
    chk("bnd.x148_who", int'(bif.who_win), 1);
  endtask

  task automatic test_match_win();
    for (int p = 3; p <= 6; p++) begin
      wait_in_game();
      land(100, 190);
      chk("win.rally_state", int'(bif.Game_state), 1);
    end
    chk("win.player6", int'(Player_score), 6);
    wait_in_game();
    land(100, 190);
    chk_all("win.end", 3, 0, 1, 7, 2);
    bif.Ball_Y = 12'd200;
    step();
    step();
    chk_all("win.hold", 3, 0, 0, 7, 2);
    bif.Ball_Y = 12'd0;
    press();
    chk_all("win.restart", 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    step();
    press();
    chk("rst.serve", int'(bif.Game_state), 1);
    for (int i = 0; i < 3; i++) begin
      wait_in_game();
      land(100, 190);
    end
    for (int i = 0; i < 2; i++) begin
      wait_in_game();
      land(200, 190);
    end
    chk_all("rst.pre", 1, 1, 1, 3, 2);
    step();
    start_btn = 1'b1;
    reset_n   = 1'b0;
    step();
    chk_all("rst.mid_wait", 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst.held_btn_ignored", int'(bif.Game_state), 0);
    start_btn = 1'b0;
    step();
    press();
    chk("rst.repress", int'(bif.Game_state), 1);
  endtask

  initial begin
    test_reset();
    test_serve_delay();
    test_player_point();
    test_npc_hold();
    test_boundary();
    test_match_win();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
